// File: rtl/y_demux_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y_pkg
// Description : Shared defaults, slot-state encoding and clog2 helper for the
//               registered demultiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package y_pkg;

    localparam int Y_SIZE_DEF = 32;
    localparam int Y_NOUT_DEF = 4;

    localparam logic [0:0] Y_EMPTY = 1'b0;
    localparam logic [0:0] Y_FULL  = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/y_demux_reg_slot.sv
`default_nettype none
// ============================================================================
// Module      : y_demux_slot
// Description : One-entry holding register with valid flag for one channel.
// Revision    : 1.0 - initial release
// ============================================================================
module y_demux_slot
    import y_pkg::*;
#(
    parameter int SIZE = Y_SIZE_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr,
    input  logic [SIZE-1:0] wdata,
    input  logic            rd,
    output logic            valid,
    output logic [SIZE-1:0] data
);

    logic [0:0]      r_state;
    logic [SIZE-1:0] r_data;

    // A write wins over a read: the old word is delivered on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= Y_EMPTY;
            r_data  <= '0;
        end else if (wr) begin
            r_state <= Y_FULL;
            r_data  <= wdata;
        end else if (rd) begin
            r_state <= Y_EMPTY;
        end
    end

    assign valid = (r_state == Y_FULL);
    assign data  = r_data;

endmodule
`default_nettype wire

// File: rtl/y_demux_reg.sv
`default_nettype none
// ============================================================================
// Module      : y_demux_reg
// Description : Registered 1:NOUT demultiplexer with per-channel valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module y_demux_reg
    import y_pkg::*;
#(
    parameter int SIZE = Y_SIZE_DEF,
    parameter int NOUT = Y_NOUT_DEF,
    parameter int SELW = clog2(NOUT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SELW-1:0]      in_sel,
    input  logic [SIZE-1:0]      in_data,
    output logic [NOUT-1:0]      out_valid,
    input  logic [NOUT-1:0]      out_ready,
    output logic [NOUT*SIZE-1:0] out_data,
    output logic                 err_sel
);

    localparam int c_selSpan = 1 << SELW;

    logic [c_selSpan-1:0] w_readyPad;
    logic [c_selSpan-1:0] w_illHit;
    logic [NOUT-1:0]      w_wr;
    logic                 w_illegal;
    logic                 r_errSel;

    // Select codes past NOUT always read ready so an illegal word is dropped.
    genvar k;
    generate
        for (k = 0; k < c_selSpan; k++) begin : g_decode
            localparam logic [SELW-1:0] c_idx = SELW'(k);
            if (k < NOUT) begin : g_legal
                assign w_readyPad[k] = ~out_valid[k] | out_ready[k];
                assign w_illHit[k]   = 1'b0;
                assign w_wr[k]       = in_valid & (in_sel == c_idx) & w_readyPad[k];
            end else begin : g_illegal
                assign w_readyPad[k] = 1'b1;
                assign w_illHit[k]   = (in_sel == c_idx);
            end
        end

        for (k = 0; k < NOUT; k++) begin : g_slot
            y_demux_slot #(
                .SIZE(SIZE)
            ) slot (
                .clk  (clk),
                .rst_n(rst_n),
                .wr   (w_wr[k]),
                .wdata(in_data),
                .rd   (out_ready[k]),
                .valid(out_valid[k]),
                .data (out_data[k*SIZE +: SIZE])
            );
        end
    endgenerate

    assign w_illegal = |w_illHit;
    assign in_ready  = w_readyPad[in_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errSel <= 1'b0;
        end else if (in_valid & w_illegal) begin
            r_errSel <= 1'b1;
        end
    end

    assign err_sel = r_errSel;

endmodule
`default_nettype wire
